// File: rtl/spi_responder_pkg.sv
// Shared defaults and FSM state encoding for the SPI responder and its synchronizer.
// Pure declarations: no latency, no backpressure.
package spi_responder_pkg;

    localparam int         DATA_WIDTH_DEF = 8;
    localparam logic [7:0] IDLE_WORD_DEF  = 8'h00;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/spi_responder_sync.sv
// N-flop synchronizer plus one delay flop giving registered rise/fall pulses.
// Latency SYNC_STAGES+1 cycles to level/pulses; free-running, no backpressure.
module spi_responder_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    // Level is taken from the delay flop so it lines up with the edge pulses.
    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_responder.sv
// Mode-0 SPI target oversampled in WB_CLK; rx word appears SYNC_STAGES+2 cycles after last SCK rise.
// rx is held until accepted (overwrite sets overrun); tx is a one-entry buffer refused while full.
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = DATA_WIDTH'(IDLE_WORD_DEF)
) (
    input  logic                  WB_CLK,
    input  logic                  WB_RST_n,
    input  logic                  SPI_sclk_i,
    input  logic                  SPI_mosi_i,
    input  logic                  SPI_cs_n_i,
    output logic                  SPI_miso_o,
    output logic                  SPI_miso_oe_o,
    output logic                  SPI_drdy_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic                  rx_overrun_o,
    output logic                  tx_underrun_o,
    input  logic                  clr_flags_i
);

    localparam int               CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_WIDTH - 1);

    logic sck_lvl, sck_rise, sck_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic unused_sync;

    spi_responder_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk_i(WB_CLK), .rst_n_i(WB_RST_n), .async_i(SPI_sclk_i),
        .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
    );
    spi_responder_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i(WB_CLK), .rst_n_i(WB_RST_n), .async_i(SPI_mosi_i),
        .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );
    spi_responder_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk_i(WB_CLK), .rst_n_i(WB_RST_n), .async_i(SPI_cs_n_i),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    assign unused_sync = ^{sck_lvl, mosi_rise, mosi_fall, cs_lvl};

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    word_done_q, word_done_d;
    logic [DATA_WIDTH-1:0]   tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-2:0]   rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0]   tx_buf_q, tx_buf_d;
    logic                    tx_full_q, tx_full_d;
    logic                    oe_q, oe_d;
    logic                    drdy_q, drdy_d;
    logic                    ovr_q, ovr_d;
    logic                    udr_q, udr_d;
    logic                    load;
    logic                    word_fin;
    logic [DATA_WIDTH-1:0]   rx_word;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        word_done_d = word_done_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        tx_buf_d    = tx_buf_q;
        tx_full_d   = tx_full_q;
        oe_d        = oe_q;
        ovr_d       = ovr_q & ~clr_flags_i;
        udr_d       = udr_q & ~clr_flags_i;
        load        = 1'b0;
        word_fin    = 1'b0;
        rx_word     = {rx_sr_q, mosi_lvl};

        if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d     = ST_SHIFT;
                    load        = 1'b1;
                    count_d     = '0;
                    word_done_d = 1'b0;
                    oe_d        = 1'b1;
                end
            end
            ST_SHIFT: begin
                // Deselect wins over any SCK edge seen in the same cycle.
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    count_d     = '0;
                    word_done_d = 1'b0;
                    oe_d        = 1'b0;
                    tx_sr_d     = '0;
                    rx_sr_d     = '0;
                end else if (sck_rise) begin
                    rx_sr_d = rx_word[DATA_WIDTH-2:0];
                    if (count_q == LAST) begin
                        word_fin    = 1'b1;
                        count_d     = '0;
                        word_done_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else if (sck_fall) begin
                    if (word_done_q) begin
                        load        = 1'b1;
                        word_done_d = 1'b0;
                    end else begin
                        tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A word arriving in the same cycle as a load is not visible to that load.
        if (load) begin
            if (tx_full_q) begin
                tx_sr_d   = tx_buf_q;
                tx_full_d = 1'b0;
            end else begin
                tx_sr_d = IDLE_WORD;
                udr_d   = 1'b1;
            end
        end

        if (tx_valid_i && !tx_full_q) begin
            tx_buf_d  = tx_data_i;
            tx_full_d = 1'b1;
        end

        if (word_fin) begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_ready_i) begin
                ovr_d = 1'b1;
            end
        end

        drdy_d = tx_full_d & (state_d == ST_IDLE);
    end

    always_ff @(posedge WB_CLK) begin
        if (!WB_RST_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            word_done_q <= 1'b0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            oe_q        <= 1'b0;
            drdy_q      <= 1'b0;
            ovr_q       <= 1'b0;
            udr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            word_done_q <= word_done_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
            oe_q        <= oe_d;
            drdy_q      <= drdy_d;
            ovr_q       <= ovr_d;
            udr_q       <= udr_d;
        end
    end

    assign SPI_miso_o    = oe_q & tx_sr_q[DATA_WIDTH-1];
    assign SPI_miso_oe_o = oe_q;
    assign SPI_drdy_o    = drdy_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_ready_o    = ~tx_full_q;
    assign rx_overrun_o  = ovr_q;
    assign tx_underrun_o = udr_q;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: a vector table of single-word transfers plus
// hand-written sequences for multi-word, aborted-word and mid-word reset cases.
module tb_spi_responder;

    logic       WB_CLK = 1'b0;
    logic       WB_RST_n = 1'b0;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs_n = 1'b1;
    logic       miso, miso_oe, drdy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ovr, udr;
    logic       clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 WB_CLK = ~WB_CLK;

    spi_responder dut (
        .WB_CLK(WB_CLK), .WB_RST_n(WB_RST_n),
        .SPI_sclk_i(sclk), .SPI_mosi_i(mosi), .SPI_cs_n_i(cs_n),
        .SPI_miso_o(miso), .SPI_miso_oe_o(miso_oe), .SPI_drdy_o(drdy),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_overrun_o(ovr), .tx_underrun_o(udr), .clr_flags_i(clr)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tx_load(input logic [7:0] d);
        int t = 0;
        while (!tx_ready && t < 50) begin
            @(negedge WB_CLK);
            t++;
        end
        check1("tx_ready_wait", tx_ready, 1'b1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge WB_CLK);
        tx_valid = 1'b0;
    endtask

    // SCK half period of 4 WB_CLK; MISO sampled just before each rise. Leaves SCK high.
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            sclk = 1'b0;
            mosi = mo[7-k];
            repeat (4) @(negedge WB_CLK);
            mi[7-k] = miso;
            sclk = 1'b1;
            repeat (4) @(negedge WB_CLK);
        end
    endtask

    task automatic select_cs();
        cs_n = 1'b0;
        repeat (8) @(negedge WB_CLK);
    endtask

    task automatic deselect_cs();
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge WB_CLK);
    endtask

    task automatic wait_rx();
        int t = 0;
        while (!rx_valid && t < 20) begin
            @(negedge WB_CLK);
            t++;
        end
        check1("rx_valid_wait", rx_valid, 1'b1);
    endtask

    task automatic accept_rx();
        rx_ready = 1'b1;
        @(negedge WB_CLK);
        rx_ready = 1'b0;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        @(negedge WB_CLK);
        clr = 1'b0;
    endtask

    typedef struct {
        logic       load;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        logic       exp_udr;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1'b0};
        vecs[1] = '{1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b1};
        vecs[3] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E, 1'b0};

        repeat (3) @(negedge WB_CLK);
        check1("rst_miso", miso, 1'b0);
        check1("rst_oe", miso_oe, 1'b0);
        check1("rst_drdy", drdy, 1'b0);
        check8("rst_rx_data", rx_data, 8'h00);
        check1("rst_rx_valid", rx_valid, 1'b0);
        check1("rst_tx_ready", tx_ready, 1'b1);
        check1("rst_ovr", ovr, 1'b0);
        check1("rst_udr", udr, 1'b0);
        WB_RST_n = 1'b1;
        repeat (8) @(negedge WB_CLK);

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].load) tx_load(vecs[i].tx);
            check1($sformatf("v%0d_drdy_idle", i), drdy, vecs[i].load);
            select_cs();
            check1($sformatf("v%0d_drdy_sel", i), drdy, 1'b0);
            check1($sformatf("v%0d_oe_sel", i), miso_oe, 1'b1);
            xfer(vecs[i].mo, 8, got);
            check8($sformatf("v%0d_miso", i), got, vecs[i].exp_miso);
            wait_rx();
            check8($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_rx);
            check1($sformatf("v%0d_udr", i), udr, vecs[i].exp_udr);
            check1($sformatf("v%0d_ovr", i), ovr, 1'b0);
            deselect_cs();
            check1($sformatf("v%0d_oe_desel", i), miso_oe, 1'b0);
            check1($sformatf("v%0d_miso_desel", i), miso, 1'b0);
            accept_rx();
            check1($sformatf("v%0d_rx_valid_acc", i), rx_valid, 1'b0);
            clr_pulse();
            check1($sformatf("v%0d_udr_clr", i), udr, 1'b0);
        end

        // Two words under one CS with the buffer refilled after the first load.
        rx_ready = 1'b1;
        tx_load(8'h11);
        select_cs();
        check1("two_tx_ready_after_load", tx_ready, 1'b1);
        tx_load(8'h22);
        check1("two_tx_ready_refilled", tx_ready, 1'b0);
        check1("two_drdy_busy", drdy, 1'b0);
        xfer(8'h01, 8, got);
        check8("two_miso_w0", got, 8'h11);
        xfer(8'h02, 8, got);
        check8("two_miso_w1", got, 8'h22);
        check8("two_rx_data", rx_data, 8'h02);
        deselect_cs();
        rx_ready = 1'b0;
        check1("two_rx_valid", rx_valid, 1'b0);
        check1("two_udr", udr, 1'b0);
        check1("two_ovr", ovr, 1'b0);
        check1("two_tx_ready_end", tx_ready, 1'b1);

        // Word aborted after 5 bits, then a full word.
        select_cs();
        xfer(8'hF0, 5, got);
        deselect_cs();
        check1("abort_rx_valid", rx_valid, 1'b0);
        check1("abort_oe", miso_oe, 1'b0);
        select_cs();
        xfer(8'hA7, 8, got);
        check8("abort_next_miso", got, 8'h00);
        wait_rx();
        check8("abort_next_rx", rx_data, 8'hA7);
        deselect_cs();
        accept_rx();
        clr_pulse();

        // Two words without acceptance: overwrite and overrun.
        select_cs();
        xfer(8'h96, 8, got);
        xfer(8'h69, 8, got);
        wait_rx();
        check8("ovr_rx_data", rx_data, 8'h69);
        check1("ovr_flag", ovr, 1'b1);
        check1("ovr_rx_valid", rx_valid, 1'b1);
        deselect_cs();

        // Reset in the middle of a word with flags, rx and tx buffer all occupied.
        tx_load(8'h33);
        select_cs();
        tx_load(8'h44);
        check1("mid_tx_ready_full", tx_ready, 1'b0);
        xfer(8'hF0, 3, got);
        WB_RST_n = 1'b0;
        @(negedge WB_CLK);
        check1("mrst_miso", miso, 1'b0);
        check1("mrst_oe", miso_oe, 1'b0);
        check1("mrst_drdy", drdy, 1'b0);
        check8("mrst_rx_data", rx_data, 8'h00);
        check1("mrst_rx_valid", rx_valid, 1'b0);
        check1("mrst_tx_ready", tx_ready, 1'b1);
        check1("mrst_ovr", ovr, 1'b0);
        check1("mrst_udr", udr, 1'b0);
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (2) @(negedge WB_CLK);
        WB_RST_n = 1'b1;
        repeat (8) @(negedge WB_CLK);

        tx_load(8'h5C);
        check1("post_rst_drdy", drdy, 1'b1);
        select_cs();
        xfer(8'h12, 8, got);
        check8("post_rst_miso", got, 8'h5C);
        wait_rx();
        check8("post_rst_rx", rx_data, 8'h12);
        check1("post_rst_udr", udr, 1'b0);
        deselect_cs();
        accept_rx();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
